hit_conditioner: RTL
====================

Name: hit_conditioner

Overview:
Front-end stage between the four raw player buttons and the game core's hit/score logic. It synchronises and debounces each button. On each confirmed press it emits a one-cycle press pulse and a fixed-length hit window. It also produces an active-low anode-coded hit vector, directly comparable with the mole anode pattern (4'b1110 = hole 1 ... 4'b0111 = hole 4). It replaces ad-hoc per-button counters clocked on button edges with fully synchronous, single-clock logic.

Parameters:
DEBOUNCE_CYCLES, 1000000, cycles the synchronised level must stay stable to confirm a press or a release (10 ms at 100 MHz); minimum 2.
HOLD_CYCLES, 100000, length of the hit window asserted per confirmed press; minimum 1.
CNT_W, 20, width of the debounce and hold counters; must hold max(DEBOUNCE_CYCLES, HOLD_CYCLES).

Ports:
clk  input  1  system clock; the only clock in the block.
reset  input  1  asynchronous, active-high reset (driven from RESTART).
btn_raw  input  4  raw buttons, bit0 = hole 1 ... bit3 = hole 4; asynchronous, active-high.
enable  input  1  1 = game running (SWITCH low); 0 = new hits suppressed.
hit_pulse  output  4  one-cycle pulse per confirmed press.
hit_hold  output  4  per-hole hit window, HOLD_CYCLES long.
hit_anode  output  4  active-low one-hot of the lowest-index active hit_hold bit; 4'b1111 when none is active.
multi_hit  output  1  more than one hit_hold bit is active.

Behaviour:
- Reset (async, any time, including mid-debounce or mid-hold): sync flops = 0, all channel FSMs = IDLE, all counters = 0, hit_pulse = 0, hit_hold = 0. After reset, hit_anode = 4'b1111 and multi_hit = 0.
- Synchroniser: 2-flop per bit. The FSM sees the synced level s.
- Per-channel FSM has states IDLE, PRESS_DB, HELD, REL_DB, with counter dcnt.
  - IDLE: s=1 -> PRESS_DB, dcnt=0.
  - PRESS_DB: s=0 -> IDLE (glitch rejected, no output). s=1 and dcnt==DEBOUNCE_CYCLES-1 -> HELD and launch a hit. Otherwise dcnt++.
  - HELD: s=0 -> REL_DB, dcnt=0.
  - REL_DB: s=1 -> HELD (release glitch, no new hit). s=0 and dcnt==DEBOUNCE_CYCLES-1 -> IDLE. Otherwise dcnt++.
- Launch a hit (only when enable=1): hit_pulse[i]=1 for exactly that one cycle, and the hold counter is loaded with HOLD_CYCLES.
  - hit_hold[i] is 1 while the hold counter > 0, so it starts in the same cycle as the pulse and lasts exactly HOLD_CYCLES cycles.
  - The hold window is independent of release.
- enable=0 at the launch edge: the FSM still moves to HELD but nothing is launched. A button held across an enable rise therefore produces no hit; the player must release and press again.
- enable falling does not cut an active hold window.
- Press latency: if btn_raw is high and stable from before edge k, hit_pulse is registered at edge k+DEBOUNCE_CYCLES+1.
- Retrigger: a launch on a channel whose hold counter is already nonzero reloads it to HOLD_CYCLES. In practice this needs a full release debounce first.
- Channels are fully independent; simultaneous presses launch in the same cycle.
- hit_anode and multi_hit are combinational from the hit_hold registers.
  - Priority for hit_anode: hole 1 > 2 > 3 > 4.
  - multi_hit=1 iff popcount(hit_hold) ≥ 2.
- Counters never wrap. dcnt resets on every state entry, and the hold counter saturates at 0.

Decomposition:
- Shared package (whack_pkg) holds:
  - NUM_HOLES = 4
  - the channel state enum {IDLE, PRESS_DB, HELD, REL_DB}
  - anode codes ANODE_H1 = 4'b1110, ANODE_H2 = 4'b1101, ANODE_H3 = 4'b1011, ANODE_H4 = 4'b0111, ANODE_NONE = 4'b1111
- One sub-module, hit_channel_debounce (synchroniser + FSM + hold counter, 1 bit wide), instantiated NUM_HOLES times.
- The top level adds the anode priority encoder and multi_hit.

Test Plan:
(All with DEBOUNCE_CYCLES=4, HOLD_CYCLES=6, enable=1 unless stated.)
1. Clean press: btn_raw[0] rises before edge 10 and is held 20 cycles -> hit_pulse[0]=1 only after edge 15; hit_hold[0]=1 after edges 15–20; hit_anode=4'b1110 in that window, 4'b1111 otherwise; exactly one pulse.
2. Glitch rejection: btn_raw[2] high for 3 cycles, then low -> hit_pulse and hit_hold stay 0 throughout.
3. Release bounce: hole 2 pressed and confirmed, then dropped low for 2 cycles and raised again -> no second hit_pulse. A full 4-cycle low, followed by a new 5-cycle press, -> exactly one second pulse.
4. Simultaneous: btn_raw = 4'b1010 rising together -> hit_pulse = 4'b1010 in the same cycle; hit_anode = 4'b1101; multi_hit = 1 for 6 cycles.
5. Enable gating: press hole 4 with enable=0, then set enable=1 while still held -> no pulse. Release, re-press -> pulse at the expected latency.
6. Reset mid-hold: assert reset 3 cycles into hit_hold[1] -> all outputs = 0 / 4'b1111 immediately (async). After deassert, a still-held button needs the full sync + debounce again before a pulse.

Source files
------------

// File: rtl/whack_pkg.sv
// Shared definitions for the whack-a-mole front end.
//   NUM_HOLES      : number of player buttons / mole holes
//   chan_state_t   : per-button debounce FSM state
//   ANODE_*        : active-low anode codes, one per hole, plus "no hole"
//   count_ones()   : population count of a hole vector
package whack_pkg;

  localparam int NUM_HOLES = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRESS_DB = 2'd1,
    HELD     = 2'd2,
    REL_DB   = 2'd3
  } chan_state_t;

  localparam logic [NUM_HOLES-1:0] ANODE_H1   = 4'b1110;
  localparam logic [NUM_HOLES-1:0] ANODE_H2   = 4'b1101;
  localparam logic [NUM_HOLES-1:0] ANODE_H3   = 4'b1011;
  localparam logic [NUM_HOLES-1:0] ANODE_H4   = 4'b0111;
  localparam logic [NUM_HOLES-1:0] ANODE_NONE = 4'b1111;

  function automatic logic [2:0] count_ones(input logic [NUM_HOLES-1:0] v);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < NUM_HOLES; i++) begin
      n = n + {2'b00, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/hit_channel_debounce.sv
// One button channel: 2-flop synchroniser, press/release debounce FSM and
// hit-window counter.
//   clk     : system clock
//   reset   : asynchronous, active-high
//   btn     : raw asynchronous button level (active-high)
//   enable  : 1 = confirmed presses launch a hit
//   pulse   : one-cycle pulse on each launched hit
//   hold    : hit window, HOLD_CYCLES long from the pulse cycle
module hit_channel_debounce
  import whack_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int HOLD_CYCLES     = 100000,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  input  logic enable,
  output logic pulse,
  output logic hold
);

  // The transition out of a stable state already consumes the first sample
  // of the new level, so dcnt only counts the remaining DEBOUNCE_CYCLES-1
  // samples and the terminal count is DEBOUNCE_CYCLES-2. With the two
  // synchroniser flops this puts the pulse DEBOUNCE_CYCLES+1 edges after
  // the raw level is first captured.
  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 2);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES);

  logic             sync_meta_reg;
  logic             sync_reg;
  chan_state_t      state_reg;
  chan_state_t      state_next;
  logic [CNT_W-1:0] dcnt_reg;
  logic [CNT_W-1:0] dcnt_next;
  logic [CNT_W-1:0] hold_reg;
  logic [CNT_W-1:0] hold_next;
  logic             pulse_reg;
  logic             db_done;
  logic             launch;

  assign db_done = (dcnt_reg == DB_LAST);

  // State register, counters and synchroniser.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_meta_reg <= 1'b0;
      sync_reg      <= 1'b0;
      state_reg     <= IDLE;
      dcnt_reg      <= '0;
      hold_reg      <= '0;
      pulse_reg     <= 1'b0;
    end else begin
      sync_meta_reg <= btn;
      sync_reg      <= sync_meta_reg;
      state_reg     <= state_next;
      dcnt_reg      <= dcnt_next;
      hold_reg      <= hold_next;
      pulse_reg     <= launch;
    end
  end

  // Next-state logic; dcnt restarts on every state change.
  always_comb begin
    state_next = state_reg;
    dcnt_next  = dcnt_reg;
    case (state_reg)
      IDLE: begin
        if (sync_reg) begin
          state_next = PRESS_DB;
          dcnt_next  = '0;
        end
      end
      PRESS_DB: begin
        if (!sync_reg) begin
          state_next = IDLE;
          dcnt_next  = '0;
        end else if (db_done) begin
          state_next = HELD;
          dcnt_next  = '0;
        end else begin
          dcnt_next = dcnt_reg + CNT_W'(1);
        end
      end
      HELD: begin
        if (!sync_reg) begin
          state_next = REL_DB;
          dcnt_next  = '0;
        end
      end
      REL_DB: begin
        if (sync_reg) begin
          state_next = HELD;
          dcnt_next  = '0;
        end else if (db_done) begin
          state_next = IDLE;
          dcnt_next  = '0;
        end else begin
          dcnt_next = dcnt_reg + CNT_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
        dcnt_next  = '0;
      end
    endcase
  end

  // Output logic: a confirmed press launches a hit only while enabled.
  // A press confirmed while disabled still reaches HELD, so it can never
  // fire later without a full release first.
  always_comb begin
    launch    = (state_reg == PRESS_DB) && sync_reg && db_done && enable;
    hold_next = hold_reg;
    if (launch) begin
      hold_next = HOLD_LOAD;
    end else if (hold_reg != '0) begin
      hold_next = hold_reg - CNT_W'(1);
    end
  end

  assign pulse = pulse_reg;
  assign hold  = (hold_reg != '0);

endmodule

// File: rtl/hit_conditioner.sv
// Button front end for the game core: per-hole debounce channels plus a
// priority anode encoder of the active hit windows.
//   clk        : system clock
//   reset      : asynchronous, active-high
//   btn_raw    : raw buttons, bit0 = hole 1 ... bit3 = hole 4
//   enable     : 1 = game running, new hits allowed
//   hit_pulse  : one-cycle pulse per confirmed press
//   hit_hold   : per-hole hit window
//   hit_anode  : active-low code of the lowest active hole, 4'b1111 if none
//   multi_hit  : two or more hit windows active
module hit_conditioner
  import whack_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int HOLD_CYCLES     = 100000,
  parameter int CNT_W           = 20
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_HOLES-1:0] btn_raw,
  input  logic                 enable,
  output logic [NUM_HOLES-1:0] hit_pulse,
  output logic [NUM_HOLES-1:0] hit_hold,
  output logic [NUM_HOLES-1:0] hit_anode,
  output logic                 multi_hit
);

  generate
    for (genvar gi = 0; gi < NUM_HOLES; gi++) begin : g_chan
      hit_channel_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .HOLD_CYCLES    (HOLD_CYCLES),
        .CNT_W          (CNT_W)
      ) u_chan (
        .clk   (clk),
        .reset (reset),
        .btn   (btn_raw[gi]),
        .enable(enable),
        .pulse (hit_pulse[gi]),
        .hold  (hit_hold[gi])
      );
    end
  endgenerate

  // Hole 1 has the highest priority.
  always_comb begin
    hit_anode = ANODE_NONE;
    if (hit_hold[0]) begin
      hit_anode = ANODE_H1;
    end else if (hit_hold[1]) begin
      hit_anode = ANODE_H2;
    end else if (hit_hold[2]) begin
      hit_anode = ANODE_H3;
    end else if (hit_hold[3]) begin
      hit_anode = ANODE_H4;
    end
  end

  assign multi_hit = (count_ones(hit_hold) >= 3'd2);

endmodule
